// File: rtl/srp_pkg.sv
// srp_pkg: shared state encoding and default sizing
// for the sample-RAM capture arbiter.
package srp_pkg;

  localparam int DEPTH_DEF    = 2096;
  localparam int AW_DEF       = 12;
  localparam int POST_CNT_DEF = 1024;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_CAPTURE = 2'd1,
    S_POST    = 2'd2,
    S_FROZEN  = 2'd3
  } state_t;

endpackage

// File: rtl/srp_buf_arbiter.sv
// srp_buf_arbiter: circular sample capture with trigger/freeze
// and a relative-address read port sharing one single-port RAM.
//
// Ports:
//   clk, rst_n            clock, async active-low reset
//   arm, trig             restart capture, trigger pulse
//   wr_valid/data/ready   sample stream in
//   rd_req/addr/ready     read request (offset from trigger)
//   rd_valid/data/err     read response, one cycle later
//   frozen, trig_addr     capture status
//   bram_*                single-port RAM, 1-cycle read
module srp_buf_arbiter
  import srp_pkg::*;
#(
  parameter int DEPTH    = DEPTH_DEF,
  parameter int AW       = AW_DEF,
  parameter int POST_CNT = POST_CNT_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          arm,
  input  logic          trig,
  input  logic          wr_valid,
  input  logic [31:0]   wr_data,
  output logic          wr_ready,
  input  logic          rd_req,
  input  logic [AW-1:0] rd_addr,
  output logic          rd_ready,
  output logic          rd_valid,
  output logic [31:0]   rd_data,
  output logic          rd_err,
  output logic          frozen,
  output logic [AW-1:0] trig_addr,
  output logic          bram_en,
  output logic          bram_we,
  output logic [AW-1:0] bram_addr,
  output logic [31:0]   bram_di,
  input  logic [31:0]   bram_dout
);

  localparam logic [AW-1:0] LAST_A =
    AW'(DEPTH - 1);
  localparam logic [AW:0] DEPTH_X =
    (AW+1)'(DEPTH);
  localparam logic [AW-1:0] POST_LAST =
    AW'(POST_CNT - 1);

  state_t        state;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] wr_ptr_nxt;
  logic [AW-1:0] post_cnt;
  logic          frozen_q;
  logic [AW-1:0] trig_q;
  logic          rd_valid_q;
  logic          rd_err_q;

  logic          wr_acc;
  logic          rd_acc;
  logic          rd_oor;
  logic          trig_hit;
  logic          post_done;
  logic [AW:0]   sum;
  logic [AW:0]   phys_x;
  logic [AW-1:0] phys;

  assign wr_ready = (state == S_CAPTURE)
                  | (state == S_POST);
  assign wr_acc   = wr_valid & wr_ready;

  // Writes always win the RAM port.
  assign rd_ready = ~wr_acc;

  // A read in the reset cycle must not
  // touch the RAM nor produce a response.
  assign rd_acc = rd_req & rd_ready & rst_n;

  assign rd_oor = {1'b0, rd_addr} >= DEPTH_X;

  // Both operands are below DEPTH whenever
  // the result is used, so one subtraction
  // is enough to wrap.
  assign sum    = {1'b0, trig_q}
                + {1'b0, rd_addr};
  assign phys_x = (sum >= DEPTH_X)
                ? sum - DEPTH_X
                : sum;
  assign phys   = phys_x[AW-1:0];

  assign wr_ptr_nxt = (wr_ptr == LAST_A)
                    ? '0
                    : wr_ptr + 1'b1;

  assign trig_hit = (state == S_CAPTURE)
                  & trig & ~arm;

  // A write in the trigger cycle is the
  // first post-trigger sample; post_cnt is
  // zero throughout CAPTURE.
  assign post_done = wr_acc & ~arm
                   & (post_cnt == POST_LAST)
                   & (trig_hit
                      | (state == S_POST));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      wr_ptr   <= '0;
      post_cnt <= '0;
      trig_q   <= '0;
      frozen_q <= 1'b0;
    end else begin
      if (wr_acc) begin
        wr_ptr <= wr_ptr_nxt;
      end
      if (arm) begin
        state    <= S_CAPTURE;
        wr_ptr   <= '0;
        post_cnt <= '0;
        frozen_q <= 1'b0;
      end else begin
        unique case (state)
          S_CAPTURE: begin
            if (trig) begin
              trig_q <= wr_ptr;
              if (wr_acc) begin
                post_cnt <= post_cnt + 1'b1;
              end
              if (post_done) begin
                state    <= S_FROZEN;
                frozen_q <= 1'b1;
              end else begin
                state <= S_POST;
              end
            end
          end
          S_POST: begin
            if (wr_acc) begin
              post_cnt <= post_cnt + 1'b1;
            end
            if (post_done) begin
              state    <= S_FROZEN;
              frozen_q <= 1'b1;
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_valid_q <= 1'b0;
      rd_err_q   <= 1'b0;
    end else begin
      rd_valid_q <= rd_acc;
      rd_err_q   <= rd_acc & rd_oor;
    end
  end

  always_comb begin
    bram_en   = 1'b0;
    bram_we   = 1'b0;
    bram_addr = wr_ptr;
    bram_di   = wr_data;
    unique case (1'b1)
      wr_acc: begin
        bram_en = 1'b1;
        bram_we = 1'b1;
      end
      (rd_acc & ~rd_oor): begin
        bram_en   = 1'b1;
        bram_addr = phys;
      end
      default: begin
      end
    endcase
  end

  assign rd_valid  = rd_valid_q;
  assign rd_err    = rd_err_q;
  assign rd_data   = rd_err_q ? '0 : bram_dout;
  assign frozen    = frozen_q;
  assign trig_addr = trig_q;

endmodule

// File: tb/tb_srp_buf_arbiter.sv
// tb_srp_buf_arbiter: randomized self-checking bench with
// a behavioural RAM and a shadow model of captured samples.
module tb_srp_buf_arbiter;

  localparam int DEPTH    = 2096;
  localparam int AW       = 12;
  localparam int POST_CNT = 1024;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          arm = 1'b0;
  logic          trig = 1'b0;
  logic          wr_valid = 1'b0;
  logic [31:0]   wr_data = '0;
  logic          wr_ready;
  logic          rd_req = 1'b0;
  logic [AW-1:0] rd_addr = '0;
  logic          rd_ready;
  logic          rd_valid;
  logic [31:0]   rd_data;
  logic          rd_err;
  logic          frozen;
  logic [AW-1:0] trig_addr;
  logic          bram_en;
  logic          bram_we;
  logic [AW-1:0] bram_addr;
  logic [31:0]   bram_di;
  logic [31:0]   bram_dout;

  int total = 0;
  int bad = 0;

  logic [31:0] mem [DEPTH];
  logic [31:0] ref_mem [DEPTH];
  int exp_ptr = 0;

  srp_buf_arbiter #(
    .DEPTH(DEPTH), .AW(AW), .POST_CNT(POST_CNT)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .arm(arm), .trig(trig),
    .wr_valid(wr_valid), .wr_data(wr_data),
    .wr_ready(wr_ready),
    .rd_req(rd_req), .rd_addr(rd_addr),
    .rd_ready(rd_ready),
    .rd_valid(rd_valid), .rd_data(rd_data),
    .rd_err(rd_err),
    .frozen(frozen), .trig_addr(trig_addr),
    .bram_en(bram_en), .bram_we(bram_we),
    .bram_addr(bram_addr), .bram_di(bram_di),
    .bram_dout(bram_dout)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (bram_en) begin
      if (bram_we) mem[bram_addr] <= bram_di;
      else bram_dout <= mem[bram_addr];
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_arm;
    arm = 1'b1;
    wr_valid = 1'b0;
    tick();
    arm = 1'b0;
    exp_ptr = 0;
  endtask

  // Stream n samples with random gaps; the
  // shadow model places each at the next slot.
  task automatic push_words(input int n,
                            input logic [31:0] base,
                            output bit ok);
    int got = 0;
    int cyc = 0;
    ok = 1'b1;
    while (got < n) begin
      wr_valid = ($urandom % 4) != 0;
      wr_data = base + got;
      #1;
      if (wr_valid && wr_ready) begin
        ref_mem[exp_ptr] = wr_data;
        exp_ptr = (exp_ptr + 1) % DEPTH;
        got++;
      end
      @(posedge clk);
      #1;
      cyc++;
      if (cyc > n * 8 + 100) begin
        ok = 1'b0;
        break;
      end
    end
    wr_valid = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    rd_req = 1'b1;
    wr_valid = 1'b1;
    arm = 1'b1;
    repeat (3) tick();
    total++;
    if (frozen !== 1'b0) begin
      bad++;
      $display("FAIL rst_frozen got=%0h exp=0", frozen);
    end
    total++;
    if (wr_ready !== 1'b0) begin
      bad++;
      $display("FAIL rst_wr_ready got=%0h exp=0", wr_ready);
    end
    total++;
    if (rd_valid !== 1'b0 || rd_err !== 1'b0) begin
      bad++;
      $display("FAIL rst_rd got=%0h/%0h exp=0/0",
               rd_valid, rd_err);
    end
    total++;
    if (trig_addr !== '0) begin
      bad++;
      $display("FAIL rst_trig_addr got=%0h exp=0", trig_addr);
    end
    total++;
    if (bram_en !== 1'b0) begin
      bad++;
      $display("FAIL rst_bram_en got=%0h exp=0", bram_en);
    end
    rd_req = 1'b0;
    wr_valid = 1'b0;
    arm = 1'b0;
    #2 rst_n = 1'b1;
    tick();
    total++;
    if (wr_ready !== 1'b0 || rd_valid !== 1'b0) begin
      bad++;
      $display("FAIL idle_after_rst got=%0h/%0h exp=0/0",
               wr_ready, rd_valid);
    end
  endtask

  task automatic test_wrap;
    int k = 0;
    int cyc = 0;
    do_arm();
    while (k < 3000 && cyc < 20000) begin
      wr_valid = ($urandom % 4) != 0;
      wr_data = k;
      #1;
      if (wr_valid && wr_ready) begin
        total++;
        if (bram_en !== 1'b1 || bram_we !== 1'b1 ||
            bram_addr !== AW'(exp_ptr) ||
            bram_di !== 32'(k)) begin
          bad++;
          $display("FAIL wr_port k=%0d got=%0h/%0h/%0h exp=1/1/%0h",
                   k, bram_en, bram_we, bram_addr, exp_ptr);
        end
        ref_mem[exp_ptr] = k;
        exp_ptr = (exp_ptr + 1) % DEPTH;
        k++;
      end
      tick();
      cyc++;
    end
    wr_valid = 1'b0;
    total++;
    if (k != 3000) begin
      bad++;
      $display("FAIL wrap_timeout got=%0d exp=3000", k);
    end
    total++;
    if (frozen !== 1'b0) begin
      bad++;
      $display("FAIL wrap_frozen got=%0h exp=0", frozen);
    end
    rd_req = 1'b1;
    rd_addr = 0;
    tick();
    rd_addr = 903;
    total++;
    if (rd_valid !== 1'b1 || rd_data !== 32'd2096) begin
      bad++;
      $display("FAIL wrap_addr0 got=%0h/%0d exp=1/2096",
               rd_valid, rd_data);
    end
    tick();
    rd_req = 1'b0;
    total++;
    if (rd_valid !== 1'b1 || rd_data !== 32'd2999) begin
      bad++;
      $display("FAIL wrap_addr903 got=%0h/%0d exp=1/2999",
               rd_valid, rd_data);
    end
    tick();
  endtask

  task automatic test_capture;
    bit ok;
    do_arm();
    push_words(100, 32'hA000_0000, ok);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL cap_pre_timeout got=0 exp=1");
    end
    trig = 1'b1;
    wr_valid = 1'b0;
    tick();
    trig = 1'b0;
    total++;
    if (trig_addr !== AW'(100) || frozen !== 1'b0 ||
        wr_ready !== 1'b1) begin
      bad++;
      $display("FAIL cap_trig got=%0d/%0h/%0h exp=100/0/1",
               trig_addr, frozen, wr_ready);
    end
    push_words(POST_CNT - 1, 32'hB000_0000, ok);
    total++;
    if (!ok || frozen !== 1'b0) begin
      bad++;
      $display("FAIL cap_post got=%0h/%0h exp=1/0", ok, frozen);
    end
    wr_valid = 1'b1;
    wr_data = 32'hB000_0000 + POST_CNT - 1;
    #1;
    total++;
    if (wr_ready !== 1'b1) begin
      bad++;
      $display("FAIL cap_last_ready got=%0h exp=1", wr_ready);
    end
    ref_mem[exp_ptr] = wr_data;
    exp_ptr = (exp_ptr + 1) % DEPTH;
    tick();
    total++;
    if (frozen !== 1'b1 || wr_ready !== 1'b0 ||
        bram_en !== 1'b0) begin
      bad++;
      $display("FAIL cap_freeze got=%0h/%0h/%0h exp=1/0/0",
               frozen, wr_ready, bram_en);
    end
    wr_valid = 1'b0;
  endtask

  task automatic test_readback;
    bit          pv = 1'b0;
    bit          pe = 1'b0;
    logic [31:0] pd = '0;
    int          a;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) begin
        total++;
        if (rd_valid !== 1'b1 ||
            rd_data !== ref_mem[(100 + i - 1) % DEPTH]) begin
          bad++;
          $display("FAIL b2b_rd%0d got=%0h/%0h exp=1/%0h",
                   i - 1, rd_valid, rd_data,
                   ref_mem[(100 + i - 1) % DEPTH]);
        end
      end
      rd_req = i < 4;
      rd_addr = AW'(i);
      tick();
    end
    rd_req = 1'b0;
    for (int c = 0; c < 201; c++) begin
      total++;
      if (rd_valid !== pv ||
          (pv && (rd_err !== pe || rd_data !== pd))) begin
        bad++;
        $display("FAIL rand_rd c=%0d got=%0h/%0h/%0h exp=%0h/%0h/%0h",
                 c, rd_valid, rd_err, rd_data, pv, pe, pd);
      end
      wr_valid = $urandom % 2;
      rd_req = (c < 200) && ($urandom % 2);
      a = $urandom % 4096;
      rd_addr = AW'(a);
      #1;
      total++;
      if (rd_ready !== 1'b1) begin
        bad++;
        $display("FAIL rand_rd_ready got=%0h exp=1", rd_ready);
      end
      pv = rd_req;
      pe = a >= DEPTH;
      pd = pe ? 32'd0 : ref_mem[(100 + a) % DEPTH];
      tick();
    end
    wr_valid = 1'b0;
    rd_req = 1'b0;
  endtask

  task automatic test_wrap_read;
    bit ok;
    do_arm();
    push_words(2000, 32'hD000_0000, ok);
    trig = 1'b1;
    tick();
    trig = 1'b0;
    push_words(POST_CNT, 32'hE000_0000, ok);
    total++;
    if (!ok || frozen !== 1'b1 || trig_addr !== AW'(2000)) begin
      bad++;
      $display("FAIL wr2_setup got=%0h/%0h/%0d exp=1/1/2000",
               ok, frozen, trig_addr);
    end
    rd_req = 1'b1;
    rd_addr = 200;
    #1;
    total++;
    if (bram_en !== 1'b1 || bram_we !== 1'b0 ||
        bram_addr !== AW'(104)) begin
      bad++;
      $display("FAIL wr2_phys got=%0h/%0h/%0d exp=1/0/104",
               bram_en, bram_we, bram_addr);
    end
    tick();
    rd_addr = 2096;
    #1;
    total++;
    if (rd_valid !== 1'b1 || rd_err !== 1'b0 ||
        rd_data !== ref_mem[104]) begin
      bad++;
      $display("FAIL wr2_data got=%0h/%0h/%0h exp=1/0/%0h",
               rd_valid, rd_err, rd_data, ref_mem[104]);
    end
    total++;
    if (bram_en !== 1'b0) begin
      bad++;
      $display("FAIL oor_bram_en got=%0h exp=0", bram_en);
    end
    tick();
    rd_req = 1'b0;
    total++;
    if (rd_valid !== 1'b1 || rd_err !== 1'b1 ||
        rd_data !== 32'd0) begin
      bad++;
      $display("FAIL oor_resp got=%0h/%0h/%0h exp=1/1/0",
               rd_valid, rd_err, rd_data);
    end
    tick();
  endtask

  task automatic test_priority;
    do_arm();
    wr_valid = 1'b1;
    wr_data = 32'hC0DE_0001;
    rd_req = 1'b1;
    rd_addr = 5;
    #1;
    total++;
    if (rd_ready !== 1'b0 || bram_en !== 1'b1 ||
        bram_we !== 1'b1 || bram_addr !== '0) begin
      bad++;
      $display("FAIL prio_wr got=%0h/%0h/%0h/%0h exp=0/1/1/0",
               rd_ready, bram_en, bram_we, bram_addr);
    end
    ref_mem[0] = wr_data;
    exp_ptr = 1;
    tick();
    wr_valid = 1'b0;
    #1;
    total++;
    if (rd_valid !== 1'b0 || rd_ready !== 1'b1 ||
        bram_en !== 1'b1 || bram_we !== 1'b0 ||
        bram_addr !== AW'((2000 + 5) % DEPTH)) begin
      bad++;
      $display("FAIL prio_rd got=%0h/%0h/%0h/%0h/%0d exp=0/1/1/0/2005",
               rd_valid, rd_ready, bram_en, bram_we, bram_addr);
    end
    tick();
    rd_req = 1'b0;
    total++;
    if (rd_valid !== 1'b1 || rd_err !== 1'b0 ||
        rd_data !== ref_mem[2005]) begin
      bad++;
      $display("FAIL prio_resp got=%0h/%0h/%0h exp=1/0/%0h",
               rd_valid, rd_err, rd_data, ref_mem[2005]);
    end
  endtask

  task automatic test_arm_trig;
    bit ok;
    push_words(5, 32'hF000_0000, ok);
    arm = 1'b1;
    trig = 1'b1;
    tick();
    arm = 1'b0;
    trig = 1'b0;
    exp_ptr = 0;
    total++;
    if (trig_addr !== AW'(2000) || frozen !== 1'b0 ||
        wr_ready !== 1'b1) begin
      bad++;
      $display("FAIL arm_trig got=%0d/%0h/%0h exp=2000/0/1",
               trig_addr, frozen, wr_ready);
    end
    push_words(7, 32'hF100_0000, ok);
    trig = 1'b1;
    tick();
    trig = 1'b0;
    total++;
    if (!ok || trig_addr !== AW'(7)) begin
      bad++;
      $display("FAIL rearm_ptr got=%0h/%0d exp=1/7", ok, trig_addr);
    end
    push_words(10, 32'hF200_0000, ok);
    total++;
    if (!ok || frozen !== 1'b0 || wr_ready !== 1'b1) begin
      bad++;
      $display("FAIL mid_post got=%0h/%0h/%0h exp=1/0/1",
               ok, frozen, wr_ready);
    end
    rd_req = 1'b1;
    rd_addr = 3;
    tick();
    total++;
    if (rd_valid !== 1'b1) begin
      bad++;
      $display("FAIL pre_rst_rd got=%0h exp=1", rd_valid);
    end
    #1 rst_n = 1'b0;
    #1;
    total++;
    if (frozen !== 1'b0 || wr_ready !== 1'b0 ||
        trig_addr !== '0 || bram_en !== 1'b0 ||
        rd_valid !== 1'b0 || rd_err !== 1'b0) begin
      bad++;
      $display("FAIL async_rst got=%0h/%0h/%0h/%0h/%0h/%0h exp=0",
               frozen, wr_ready, trig_addr, bram_en,
               rd_valid, rd_err);
    end
    tick();
    total++;
    if (rd_valid !== 1'b0) begin
      bad++;
      $display("FAIL rst_cycle_rd got=%0h exp=0", rd_valid);
    end
    rd_req = 1'b0;
    rst_n = 1'b1;
    tick();
    total++;
    if (wr_ready !== 1'b0 || frozen !== 1'b0 ||
        rd_valid !== 1'b0) begin
      bad++;
      $display("FAIL post_rst_idle got=%0h/%0h/%0h exp=0/0/0",
               wr_ready, frozen, rd_valid);
    end
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
    test_reset();
    test_wrap();
    test_capture();
    test_readback();
    test_wrap_read();
    test_priority();
    test_arm_trig();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
